regfile_banked_cc: RTL

//  Parametrised successor to the LC-3 GP register file: N-entry, W-bit file, 1 write / 2 read ports.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_banked_cc_reg_cell.sv | 21 ++
 rtl/regfile_banked_cc.sv | 134 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the banked register file:
// condition-code encodings, privilege modes and the NZP derivation.
package regfile_pkg;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    localparam logic MODE_SUP = 1'b0;
    localparam logic MODE_USR = 1'b1;

    // The register width is a parameter of the file, so the caller passes
    // the sign bit and a zero flag rather than the full value.
    function automatic logic [2:0] cc_of(input logic sign, input logic is_zero);
        if (sign)
            return CC_N;
        else if (is_zero)
            return CC_Z;
        else
            return CC_P;
    endfunction

endpackage

// File: rtl/regfile_banked_cc_reg_cell.sv
// Single storage word for the register file: load-enable flop with an
// asynchronous active-low clear to a parameterised reset value.
module reg_cell #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/regfile_banked_cc.sv
// Banked register file: 1W/2R GP registers, NZP condition codes, privilege
// bit and a stack pointer swapped with saved SSP/USP on mode change.
// Optional build macro REGFILE_BYPASS_EN adds write-through read forwarding.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_SUP  | supervisor mode, priv=0, saved_ssp idle, USP banked
//   ST_USR  | user mode, priv=1, saved_usp idle, SSP banked
module regfile_banked_cc
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 8,
    parameter int                SP_IDX   = 6,
    parameter logic [DATA_W-1:0] SSP_INIT = 16'h3000,
    localparam int               ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              i_Clk,
    input  logic              reset_,
    input  logic [ADDR_W-1:0] DR,
    input  logic              LD_REG,
    input  logic [ADDR_W-1:0] SR1_SEL,
    input  logic [ADDR_W-1:0] SR2_SEL,
    input  logic [DATA_W-1:0] bus,
    input  logic              LD_CC,
    input  logic              MODE_LD,
    input  logic              NEW_MODE,
    output logic [DATA_W-1:0] sr1,
    output logic [DATA_W-1:0] sr2,
    output logic [2:0]        nzp,
    output logic              priv,
    output logic              sp_conflict
);

    localparam logic [0:0]        ST_SUP = MODE_SUP;
    localparam logic [0:0]        ST_USR = MODE_USR;
    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);

    logic [0:0]        state, state_nxt;
    logic              swap;
    logic              sp_write;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] reg_d [NUM_REGS];
    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0] saved_ssp, saved_usp;
    logic [DATA_W-1:0] sp_banked;

    assign priv     = state[0];
    assign swap     = MODE_LD && (NEW_MODE != priv);
    assign sp_write = LD_REG && (DR == SP_ADDR);

    always_comb begin
        state_nxt = state;
        if (swap)
            state_nxt = NEW_MODE ? ST_USR : ST_SUP;
    end

    always_ff @(posedge i_Clk or negedge reset_) begin
        if (!reset_)
            state <= ST_SUP;
        else
            state <= state_nxt;
    end

    // The bank being restored is the one for the mode we are entering.
    assign sp_banked = priv ? saved_ssp : saved_usp;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == SP_IDX) begin : g_sp
            assign reg_en[i] = swap || sp_write;
            assign reg_d[i]  = swap ? sp_banked : bus;
        end else begin : g_gp
            assign reg_en[i] = LD_REG && (DR == ADDR_W'(i));
            assign reg_d[i]  = bus;
        end

        reg_cell #(
            .WIDTH     (DATA_W),
            .RESET_VAL ('0)
        ) u_cell (
            .clk    (i_Clk),
            .reset_ (reset_),
            .en     (reg_en[i]),
            .d      (reg_d[i]),
            .q      (regs[i])
        );
    end

    reg_cell #(
        .WIDTH     (DATA_W),
        .RESET_VAL (SSP_INIT)
    ) u_saved_ssp (
        .clk    (i_Clk),
        .reset_ (reset_),
        .en     (swap && (priv == MODE_SUP)),
        .d      (regs[SP_IDX]),
        .q      (saved_ssp)
    );

    reg_cell #(
        .WIDTH     (DATA_W),
        .RESET_VAL ('0)
    ) u_saved_usp (
        .clk    (i_Clk),
        .reset_ (reset_),
        .en     (swap && (priv == MODE_USR)),
        .d      (regs[SP_IDX]),
        .q      (saved_usp)
    );

    always_ff @(posedge i_Clk or negedge reset_) begin
        if (!reset_) begin
            nzp         <= CC_Z;
            sp_conflict <= 1'b0;
        end else begin
            if (LD_CC)
                nzp <= cc_of(bus[DATA_W-1], bus == '0);
            sp_conflict <= swap && sp_write;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;

    // A swap owns the SP register this cycle, so its bus value never lands.
    assign fwd_ok = LD_REG && !(swap && (DR == SP_ADDR));
    assign sr1    = (fwd_ok && (DR == SR1_SEL)) ? bus : regs[SR1_SEL];
    assign sr2    = (fwd_ok && (DR == SR2_SEL)) ? bus : regs[SR2_SEL];
`else
    assign sr1 = regs[SR1_SEL];
    assign sr2 = regs[SR2_SEL];
`endif

endmodule
